encaps_sequencer: RTL and testbench
===================================

Name: encaps_sequencer

Overview:
- Central FSM that sequences the encapsulation datapath in order: unpack_rq0, then ternary with pack_s3 interleaved, then sha3_256 absorb/permute/squeeze.
- Replaces the free-running gated strobes with single-clock enables and phase-qualified resets.
- Sits between the top-level start/done handshake and the datapath sub-blocks; contains no datapath storage itself.

Parameters:
- UNPACK_BEATS, 351: unpack_rq0 beats, 2 coefficients per beat.
- TER_BEATS, 175: ternary beats, 16 random bits each.
- PACK_PERIOD, 4: ternary beats per pack_s3 group; p3_count runs 0..PACK_PERIOD-1.
- KECCAK_ROUNDS, 24: permutation rounds per absorbed block.
- CNT_W, 9: beat-counter width; must satisfy 2^CNT_W > max(UNPACK_BEATS, TER_BEATS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; ignored unless state is IDLE.
- up_done  in  1  unpack_rq0 done flag.
- ter_done  in  1  ternary done flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the key k is valid.
- up_en  out  1  unpack_rq0 clock enable.
- ter_en  out  1  ternary / pack_s3 clk1 enable.
- p3_en  out  1  pack_s3 clk2 enable.
- p3_rst  out  1  pack_s3 group reset.
- p3_stop  out  1  pack_s3 stop.
- p3_count  out  2  pack_s3 group index.
- hash_rst1  out  1  sha3 state clear.
- hash_rst2  out  1  sha3 round-counter clear.
- hash_sp  out  1  sha3 sample (absorb) strobe.
- hash_keccak  out  1  sha3 round enable.
- hash_ans  out  1  sha3 answer (squeeze) strobe.
- k_load  out  1  load enable for the k register.
- err  out  1  watchdog error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE and all counters clear.
  - All outputs are 0, except p3_rst=1 and hash_rst1=1, which hold the datapath cleared.
  - Reset asserted mid-operation aborts immediately; no done pulse follows.
- IDLE:
  - All enables are 0.
  - start=1 moves to UNPACK and clears beat_cnt.
- UNPACK:
  - up_en=1 every cycle; beat_cnt increments.
  - Moves to TERN on the cycle after up_done=1, or when beat_cnt==UNPACK_BEATS-1, whichever comes first.
  - If up_done and the count limit coincide, there is a single transition.
- TERN:
  - ter_en=1 every cycle; grp_cnt runs 0..PACK_PERIOD-1 and wraps to 0.
  - p3_count=grp_cnt.
  - p3_en=1 on the cycle grp_cnt==PACK_PERIOD-1; p3_rst pulses 1 on the following cycle.
  - On ter_done=1, or when beat_cnt==TER_BEATS-1:
    - p3_stop=1 for one cycle and a final p3_en is issued if grp_cnt!=0.
    - State moves to HASH_INIT.
- HASH_INIT: one cycle; hash_rst2=1 and hash_rst1=0; moves to ABSORB.
- ABSORB: one cycle; hash_sp=1; moves to PERMUTE with rnd_cnt=0.
- PERMUTE:
  - hash_keccak=1 for exactly KECCAK_ROUNDS consecutive cycles.
  - rnd_cnt==KECCAK_ROUNDS-1 moves to SQUEEZE.
- SQUEEZE: hash_ans=1 and k_load=1 for one cycle; moves to DONE.
- DONE: done=1 and busy=1 for one cycle; returns to IDLE.
- start outside IDLE: ignored, not queued.
- Latency from start to done is fixed at UNPACK_BEATS + TER_BEATS + KECCAK_ROUNDS + 4 cycles (UNPACK + TERN + HASH_INIT + ABSORB + PERMUTE + SQUEEZE + DONE), provided neither early done flag arrives. An early up_done or ter_done shortens it accordingly.
- Exactly one state is active at a time: one-hot or binary encoding, with an explicit default back to IDLE.

Optional Feature:
- Macro: ENCAPS_SEQ_WATCHDOG_EN.
- Compiled in:
  - In UNPACK and TERN, beat_cnt reaching its limit without the matching done flag moves the FSM to ERR.
  - ERR: err=1 and all enables=0; the block stays there until rst=0.
  - In ERR, busy=1 and done never pulses.
- Compiled out:
  - The count limit alone advances the FSM; err is tied 0 and the ERR state does not exist.

Decomposition:
- Package encaps_pkg holds:
  - state_t enum: IDLE, UNPACK, TERN, HASH_INIT, ABSORB, PERMUTE, SQUEEZE, DONE, ERR.
  - Default beat constants.
  - CNT_W derivation function.
- One natural sub-module: encaps_beat_cnt, a loadable up-counter with terminal-count flag, instanced for beat_cnt and rnd_cnt.
- grp_cnt stays inline.

Test Plan:
- Nominal run: start pulse with done flags held at 0 -> done after 351+175+24+4=554 cycles; up_en high 351 cycles; ter_en high 175; hash_keccak high 24; p3_en count = ceil(175/4) = 44.
- Early flags: up_done at beat 100, ter_done at beat 50 -> TERN entered at cycle 102, HASH_INIT after ter_done +1; exactly one p3_stop pulse.
- start held high through the whole run -> exactly one operation, then a second run starts from IDLE; no double done.
- rst=0 during PERMUTE round 10 -> next cycle state is IDLE, all enables 0, p3_rst=1 and hash_rst1=1; done never pulses.
- With ENCAPS_SEQ_WATCHDOG_EN: up_done stuck 0 -> err=1 at cycle 352 and held until reset. Without the macro: the run completes normally with err=0.

Source files
------------

// File: rtl/encaps_pkg.sv
// Shared types and default constants for the encapsulation sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package encaps_pkg;

    localparam int UNPACK_BEATS_DEF  = 351;
    localparam int TER_BEATS_DEF     = 175;
    localparam int PACK_PERIOD_DEF   = 4;
    localparam int KECCAK_ROUNDS_DEF = 24;

    // Smallest width w with 2^w > max_val, so a counter can hold max_val.
    function automatic int cnt_w(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int CNT_W_DEF = cnt_w((UNPACK_BEATS_DEF > TER_BEATS_DEF) ?
                                     UNPACK_BEATS_DEF : TER_BEATS_DEF);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        UNPACK    = 4'd1,
        TERN      = 4'd2,
        HASH_INIT = 4'd3,
        ABSORB    = 4'd4,
        PERMUTE   = 4'd5,
        SQUEEZE   = 4'd6,
        DONE      = 4'd7,
        ERR       = 4'd8
    } state_t;

endpackage

// File: rtl/encaps_beat_cnt.sv
// Loadable up-counter with a terminal-count flag against a runtime limit.
// Latency: load/increment take effect on the next clock; tc is combinational from the count.
// Backpressure: none; counts whenever inc is high, load has priority over inc.
module encaps_beat_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear on load, otherwise step when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == last);

endmodule

// File: rtl/encaps_sequencer.sv
// Central FSM sequencing unpack_rq0 -> ternary/pack_s3 -> sha3 absorb/permute/squeeze.
// Latency: start to done = UNPACK_BEATS + TER_BEATS + KECCAK_ROUNDS + 4 cycles, shorter on early done flags.
// Backpressure: none; start is honoured only in IDLE and dropped otherwise. Optional macro: ENCAPS_SEQ_WATCHDOG_EN.
module encaps_sequencer
    import encaps_pkg::*;
#(
    parameter int UNPACK_BEATS  = UNPACK_BEATS_DEF,
    parameter int TER_BEATS     = TER_BEATS_DEF,
    parameter int PACK_PERIOD   = PACK_PERIOD_DEF,
    parameter int KECCAK_ROUNDS = KECCAK_ROUNDS_DEF,
    parameter int CNT_W         = cnt_w((UNPACK_BEATS > TER_BEATS) ? UNPACK_BEATS : TER_BEATS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       up_done,
    input  logic       ter_done,
    output logic       busy,
    output logic       done,
    output logic       up_en,
    output logic       ter_en,
    output logic       p3_en,
    output logic       p3_rst,
    output logic       p3_stop,
    output logic [1:0] p3_count,
    output logic       hash_rst1,
    output logic       hash_rst2,
    output logic       hash_sp,
    output logic       hash_keccak,
    output logic       hash_ans,
    output logic       k_load,
    output logic       err
);

    localparam int         RND_W    = cnt_w(KECCAK_ROUNDS);
    localparam logic [1:0] GRP_LAST = 2'(PACK_PERIOD - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       grp_q;
    logic [1:0]       grp_d;
    logic             p3_pulse_q;
    logic             p3_pulse_d;

    logic             beat_load;
    logic             beat_inc;
    logic             beat_tc;
    logic [CNT_W-1:0] beat_last;
    logic             rnd_load;
    logic             rnd_inc;
    logic             rnd_tc;

    logic             up_exit;
    logic             tern_exit;

    // One beat counter serves both UNPACK and TERN; its limit follows the phase.
    assign beat_last = (state_q == TERN) ? CNT_W'(TER_BEATS - 1) : CNT_W'(UNPACK_BEATS - 1);

    encaps_beat_cnt #(.W(CNT_W)) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (beat_load),
        .inc  (beat_inc),
        .last (beat_last),
        .tc   (beat_tc)
    );

    encaps_beat_cnt #(.W(RND_W)) u_rnd_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (rnd_load),
        .inc  (rnd_inc),
        .last (RND_W'(KECCAK_ROUNDS - 1)),
        .tc   (rnd_tc)
    );

`ifdef ENCAPS_SEQ_WATCHDOG_EN
    // Only the done flags advance a phase; hitting the beat limit without one is a fault.
    logic wd_trip;
    assign up_exit   = up_done;
    assign tern_exit = ter_done;
    assign wd_trip   = ((state_q == UNPACK) && beat_tc && !up_done) ||
                       ((state_q == TERN)   && beat_tc && !ter_done);
`else
    // Either the done flag or the beat limit closes a phase.
    assign up_exit   = up_done | beat_tc;
    assign tern_exit = ter_done | beat_tc;
`endif

    assign p3_count   = grp_q;
    assign p3_pulse_d = p3_en;

    // State, group index and p3_rst pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            grp_q      <= '0;
            p3_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            p3_pulse_q <= p3_pulse_d;
        end
    end

    // Next state plus counter load/step controls.
    always_comb begin
        state_d   = state_q;
        grp_d     = '0;
        beat_load = 1'b0;
        beat_inc  = 1'b0;
        rnd_load  = 1'b0;
        rnd_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = UNPACK;
                    beat_load = 1'b1;
                end
            end
            UNPACK: begin
                beat_inc = 1'b1;
                if (up_exit) begin
                    state_d   = TERN;
                    beat_load = 1'b1;
                end
`ifdef ENCAPS_SEQ_WATCHDOG_EN
                else if (wd_trip) begin
                    state_d = ERR;
                end
`endif
            end
            TERN: begin
                beat_inc = 1'b1;
                if (tern_exit) begin
                    state_d = HASH_INIT;
                end
`ifdef ENCAPS_SEQ_WATCHDOG_EN
                else if (wd_trip) begin
                    state_d = ERR;
                end
`endif
                else begin
                    grp_d = (grp_q == GRP_LAST) ? 2'd0 : grp_q + 2'd1;
                end
            end
            HASH_INIT: state_d = ABSORB;
            ABSORB: begin
                state_d  = PERMUTE;
                rnd_load = 1'b1;
            end
            PERMUTE: begin
                rnd_inc = 1'b1;
                if (rnd_tc) begin
                    state_d = SQUEEZE;
                end
            end
            SQUEEZE: state_d = DONE;
            DONE:    state_d = IDLE;
`ifdef ENCAPS_SEQ_WATCHDOG_EN
            ERR:     state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Per-state strobes; idle and fault states hold pack_s3 and the sha3 state cleared.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        up_en       = 1'b0;
        ter_en      = 1'b0;
        p3_en       = 1'b0;
        p3_rst      = 1'b0;
        p3_stop     = 1'b0;
        hash_rst1   = 1'b0;
        hash_rst2   = 1'b0;
        hash_sp     = 1'b0;
        hash_keccak = 1'b0;
        hash_ans    = 1'b0;
        k_load      = 1'b0;
`ifdef ENCAPS_SEQ_WATCHDOG_EN
        err         = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                p3_rst    = 1'b1;
                hash_rst1 = 1'b1;
            end
            UNPACK: begin
                busy      = 1'b1;
                up_en     = 1'b1;
                p3_rst    = 1'b1;
                hash_rst1 = 1'b1;
            end
            TERN: begin
                busy      = 1'b1;
                ter_en    = 1'b1;
                hash_rst1 = 1'b1;
                p3_rst    = p3_pulse_q;
                p3_stop   = tern_exit;
                // A partial group still gets flushed on stop; an empty one does not.
                p3_en     = (grp_q == GRP_LAST) || (tern_exit && (grp_q != 2'd0));
            end
            HASH_INIT: begin
                busy      = 1'b1;
                hash_rst2 = 1'b1;
                p3_rst    = p3_pulse_q;
            end
            ABSORB: begin
                busy    = 1'b1;
                hash_sp = 1'b1;
            end
            PERMUTE: begin
                busy        = 1'b1;
                hash_keccak = 1'b1;
            end
            SQUEEZE: begin
                busy     = 1'b1;
                hash_ans = 1'b1;
                k_load   = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
`ifdef ENCAPS_SEQ_WATCHDOG_EN
            ERR: begin
                busy      = 1'b1;
                err       = 1'b1;
                p3_rst    = 1'b1;
                hash_rst1 = 1'b1;
            end
`endif
            default: begin
                p3_rst    = 1'b1;
                hash_rst1 = 1'b1;
            end
        endcase
    end

`ifndef ENCAPS_SEQ_WATCHDOG_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_encaps_sequencer.sv
// Directed bench for encaps_sequencer: vector table over full runs plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_encaps_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       up_done = 1'b0;
    logic       ter_done = 1'b0;
    logic       busy, done, up_en, ter_en, p3_en, p3_rst, p3_stop;
    logic [1:0] p3_count;
    logic       hash_rst1, hash_rst2, hash_sp, hash_keccak, hash_ans, k_load, err;
    logic [15:0] outs;

    encaps_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .up_done     (up_done),
        .ter_done    (ter_done),
        .busy        (busy),
        .done        (done),
        .up_en       (up_en),
        .ter_en      (ter_en),
        .p3_en       (p3_en),
        .p3_rst      (p3_rst),
        .p3_stop     (p3_stop),
        .p3_count    (p3_count),
        .hash_rst1   (hash_rst1),
        .hash_rst2   (hash_rst2),
        .hash_sp     (hash_sp),
        .hash_keccak (hash_keccak),
        .hash_ans    (hash_ans),
        .k_load      (k_load),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign outs = {busy, done, up_en, ter_en, p3_en, p3_rst, p3_stop, p3_count,
                   hash_rst1, hash_rst2, hash_sp, hash_keccak, hash_ans, k_load, err};

    localparam logic [15:0] B_BUSY = 16'h8000, B_DONE = 16'h4000, B_UP = 16'h2000, B_TER = 16'h1000;
    localparam logic [15:0] B_P3EN = 16'h0800, B_P3RST = 16'h0400, B_P3STOP = 16'h0200;
    localparam logic [15:0] C1 = 16'h0080, C2 = 16'h0100, C3 = 16'h0180;
    localparam logic [15:0] B_HR1 = 16'h0040, B_HR2 = 16'h0020, B_SP = 16'h0010, B_KEC = 16'h0008;
    localparam logic [15:0] B_ANS = 16'h0004, B_KLD = 16'h0002, B_ERR = 16'h0001;

    localparam logic [15:0] V_IDLE   = B_P3RST | B_HR1;
    localparam logic [15:0] V_UNPACK = B_BUSY | B_UP | B_P3RST | B_HR1;
    localparam logic [15:0] V_TERN   = B_BUSY | B_TER | B_HR1;
    localparam logic [15:0] V_HINIT  = B_BUSY | B_HR2;
    localparam logic [15:0] V_PERM   = B_BUSY | B_KEC;

    typedef struct packed {
        logic [9:0]  cyc;
        logic        up_done;
        logic        ter_done;
        logic [15:0] exp;
    } vec_t;

    localparam int NA = 15;
    localparam int NB = 9;
    vec_t vec [0:NA+NB-1];

    int n_tests = 0;
    int n_fail  = 0;
    int n_up, n_ter, n_kec, n_p3en, n_p3stop, n_done, n_busy, n_err, first_done, last_done;

    function automatic vec_t mkv(input int c, input logic u, input logic t, input logic [15:0] e);
        vec_t v;
        v.cyc      = 10'(c);
        v.up_done  = u;
        v.ter_done = t;
        v.exp      = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int c, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc %0d: outputs got %h want %h", name, c, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clear_counts();
        n_up = 0; n_ter = 0; n_kec = 0; n_p3en = 0; n_p3stop = 0;
        n_done = 0; n_busy = 0; n_err = 0; first_done = 0; last_done = 0;
    endtask

    task automatic sample_counts(input int c);
        n_up     += int'(up_en);
        n_ter    += int'(ter_en);
        n_kec    += int'(hash_keccak);
        n_p3en   += int'(p3_en);
        n_p3stop += int'(p3_stop);
        n_busy   += int'(busy);
        n_err    += int'(err);
        if (done) begin
            n_done++;
            last_done = c;
            if (first_done == 0) first_done = c;
        end
    endtask

    // Start a run, then per cycle: drive that cycle's flags from the table, sample, compare.
    task automatic run_vectors(input int first, input int last, input int ncyc);
        int  idx;
        bit  hit;
        idx = first;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) tick();
            hit = 1'b0;
            if (idx <= last) hit = (int'(vec[idx].cyc) == c);
            up_done  = hit ? vec[idx].up_done  : 1'b0;
            ter_done = hit ? vec[idx].ter_done : 1'b0;
            #1;
            sample_counts(c);
            if (hit) begin
                check($sformatf("vec%0d", idx), c, outs, vec[idx].exp);
                idx++;
            end
        end
        up_done  = 1'b0;
        ter_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        // Run A: nominal, no early flags.
        vec[0]  = mkv(1,   0, 0, V_UNPACK);
        vec[1]  = mkv(2,   0, 0, V_UNPACK);
        vec[2]  = mkv(351, 0, 0, V_UNPACK);
        vec[3]  = mkv(352, 0, 0, V_TERN);
        vec[4]  = mkv(355, 0, 0, V_TERN | B_P3EN | C3);
        vec[5]  = mkv(356, 0, 0, V_TERN | B_P3RST);
        vec[6]  = mkv(525, 0, 0, V_TERN | C1);
        vec[7]  = mkv(526, 0, 0, V_TERN | B_P3EN | B_P3STOP | C2);
        vec[8]  = mkv(527, 0, 0, V_HINIT | B_P3RST);
        vec[9]  = mkv(528, 0, 0, B_BUSY | B_SP);
        vec[10] = mkv(529, 0, 0, V_PERM);
        vec[11] = mkv(552, 0, 0, V_PERM);
        vec[12] = mkv(553, 0, 0, B_BUSY | B_ANS | B_KLD);
        vec[13] = mkv(554, 0, 0, B_BUSY | B_DONE);
        vec[14] = mkv(555, 0, 0, V_IDLE);
        // Run B: up_done at beat 100, ter_done at beat 50.
        vec[15] = mkv(101, 1, 0, V_UNPACK);
        vec[16] = mkv(102, 0, 0, V_TERN);
        vec[17] = mkv(105, 0, 0, V_TERN | B_P3EN | C3);
        vec[18] = mkv(152, 0, 1, V_TERN | B_P3EN | B_P3STOP | C2);
        vec[19] = mkv(153, 0, 0, V_HINIT | B_P3RST);
        vec[20] = mkv(154, 0, 0, B_BUSY | B_SP);
        vec[21] = mkv(179, 0, 0, B_BUSY | B_ANS | B_KLD);
        vec[22] = mkv(180, 0, 0, B_BUSY | B_DONE);
        vec[23] = mkv(181, 0, 0, V_IDLE);

        // Reset state.
        rst = 1'b0;
        repeat (3) tick();
        #1;
        check("reset", 0, outs, V_IDLE);
        rst = 1'b1;
        tick();
        #1;
        check("idle_after_reset", 0, outs, V_IDLE);

`ifndef ENCAPS_SEQ_WATCHDOG_EN
        run_vectors(0, NA - 1, 560);
        check_int("a_up_en_cycles", n_up, 351);
        check_int("a_ter_en_cycles", n_ter, 175);
        check_int("a_keccak_cycles", n_kec, 24);
        check_int("a_p3_en_pulses", n_p3en, 44);
        check_int("a_p3_stop_pulses", n_p3stop, 1);
        check_int("a_done_pulses", n_done, 1);
        check_int("a_latency", first_done, 554);
        check_int("a_err_cycles", n_err, 0);
`else
        // Watchdog: up_done stuck low traps in ERR at cycle 352 until reset.
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) tick();
            #1;
            sample_counts(c);
            if (c == 351) check("wd_last_unpack", c, outs, V_UNPACK);
            if (c == 352) check("wd_err_entry", c, outs, B_BUSY | B_ERR | B_P3RST | B_HR1);
        end
        check("wd_err_held", 400, outs, B_BUSY | B_ERR | B_P3RST | B_HR1);
        check_int("wd_err_cycles", n_err, 49);
        check_int("wd_done_pulses", n_done, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("wd_reset_clears", 0, outs, V_IDLE);
        tick();
`endif

        run_vectors(NA, NA + NB - 1, 190);
        check_int("b_up_en_cycles", n_up, 101);
        check_int("b_ter_en_cycles", n_ter, 51);
        check_int("b_keccak_cycles", n_kec, 24);
        check_int("b_p3_en_pulses", n_p3en, 13);
        check_int("b_p3_stop_pulses", n_p3stop, 1);
        check_int("b_latency", first_done, 180);

        // start and both done flags held high: one run at a time, back to IDLE between runs.
        clear_counts();
        up_done  = 1'b1;
        ter_done = 1'b1;
        start    = 1'b1;
        for (int c = 1; c <= 62; c++) begin
            tick();
            #1;
            sample_counts(c);
            if (c == 2)  check("c_stop_at_grp0", c, outs, V_TERN | B_P3STOP);
            if (c == 31) check("c_idle_between", c, outs, V_IDLE);
        end
        start    = 1'b0;
        up_done  = 1'b0;
        ter_done = 1'b0;
        check_int("c_first_done", first_done, 30);
        check_int("c_second_done", last_done, 61);
        check_int("c_done_pulses", n_done, 2);
        check_int("c_p3_en_pulses", n_p3en, 0);
        check_int("c_p3_stop_pulses", n_p3stop, 2);
        repeat (3) tick();

        // Reset during PERMUTE round 10 aborts with no done.
        up_done  = 1'b1;
        ter_done = 1'b1;
        start    = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start = 1'b0;
            #1;
            if (c == 15) check("d_permute_round10", c, outs, V_PERM);
        end
        up_done  = 1'b0;
        ter_done = 1'b0;
        rst = 1'b0;
        tick();
        #1;
        check("d_reset_mid_run", 16, outs, V_IDLE);
        rst = 1'b1;
        clear_counts();
        for (int c = 1; c <= 40; c++) begin
            tick();
            #1;
            sample_counts(c);
        end
        check_int("d_done_after_abort", n_done, 0);
        check_int("d_busy_after_abort", n_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
